// File: rtl/ltf_pkg.sv
// Shared constants, FSM state type and IQ halving helper for the LTF stream packer.
package ltf_pkg;

  localparam int LTF_LEN     = 160;
  localparam int LTF_CP_LEN  = 32;
  localparam int LTF_SYM_LEN = 64;

  // Periodic extension of sample LTF_LEN lands back on this sample index.
  localparam int LTF_EXT_IDX = LTF_CP_LEN + ((LTF_LEN - LTF_CP_LEN) % LTF_SYM_LEN);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

  function automatic logic [31:0] halve_iq(input logic [31:0] x);
    logic signed [15:0] i_part;
    logic signed [15:0] q_part;
    i_part = x[31:16];
    q_part = x[15:0];
    return {16'(i_part >>> 1), 16'(q_part >>> 1)};
  endfunction

endpackage

// File: rtl/ltf_stream_packer_ring_fifo.sv
// Ring buffer for the packer: storage, wrapping pointers, occupancy and a last bit
// carried as the MSB of every entry.
module ltf_ring_fifo #(
  parameter int DEPTH = 256,
  parameter int W     = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         mark_last,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty,
  output logic         full,
  output logic         dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign dropped = wr_en && !do_wr;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // A dropped final sample moves its last tag onto the newest surviving entry.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end else if (mark_last && !empty) begin
      mem[wr_ptr - PTR_ONE][W-1] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ltf_stream_packer.sv
// Captures the 160-sample LTF burst and replays it over a valid/ready stream.
// Optional LTF_WINDOW_EN: halves sample 0 and appends a halved copy of sample 32.
module ltf_stream_packer
  import ltf_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ltf_started,
  input  logic [DW-1:0] ltf_sample,
  output logic [DW-1:0] m_tdata,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic          m_tlast,
  output logic          busy,
  output logic          done,
  output logic          ovf,
  output logic          err_restart
);

`ifdef LTF_WINDOW_EN
  localparam int BURST_LEN = LTF_LEN + 1;
`else
  localparam int BURST_LEN = LTF_LEN;
`endif

  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ltf_stream_packer: DEPTH must be a power of two in 2..1024");
  end

  state_t        state, state_next;
  logic [8:0]    wr_cnt, wr_cnt_next;
  logic          busy_next, done_next, ovf_next, err_next;
  logic          wr_en, wr_last, mark_last, pop;
  logic          fifo_empty, fifo_full, dropped;
  logic [DW-1:0] wr_sample;
  logic [DW:0]   head;

`ifdef LTF_WINDOW_EN
  logic [DW-1:0] ext_sample;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_sample <= '0;
    end else if (state == S_CAPTURE && wr_cnt == 9'(LTF_EXT_IDX)) begin
      ext_sample <= ltf_sample;
    end
  end
`endif

  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = head[DW-1:0];
  assign m_tlast   = head[DW];
  assign pop       = m_tvalid && m_tready;
  assign mark_last = dropped && wr_last;

  always_comb begin
    state_next  = state;
    wr_cnt_next = wr_cnt;
    busy_next   = busy;
    done_next   = 1'b0;
    ovf_next    = ovf;
    err_next    = err_restart;
    wr_en       = 1'b0;
    wr_last     = 1'b0;
    wr_sample   = ltf_sample;
    case (state)
      S_IDLE: begin
        if (ltf_started) begin
          wr_en       = 1'b1;
          wr_cnt_next = 9'd1;
          ovf_next    = 1'b0;
          err_next    = 1'b0;
          busy_next   = 1'b1;
          state_next  = S_CAPTURE;
`ifdef LTF_WINDOW_EN
          wr_sample   = DW'(halve_iq(32'(ltf_sample)));
`endif
        end
      end
      S_CAPTURE: begin
        wr_en       = 1'b1;
        wr_cnt_next = wr_cnt + 9'd1;
        wr_last     = (wr_cnt == 9'(BURST_LEN - 1));
`ifdef LTF_WINDOW_EN
        if (wr_cnt == 9'(LTF_LEN)) wr_sample = DW'(halve_iq(32'(ext_sample)));
`endif
        if (wr_cnt_next == 9'(BURST_LEN)) state_next = S_DRAIN;
        if (ltf_started) err_next = 1'b1;
      end
      S_DRAIN: begin
        if (ltf_started) err_next = 1'b1;
        // The last-tagged entry is always the newest, so popping it empties the buffer.
        if ((pop && m_tlast) || fifo_empty) begin
          done_next  = 1'b1;
          busy_next  = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (dropped) ovf_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      wr_cnt      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      err_restart <= 1'b0;
    end else begin
      state       <= state_next;
      wr_cnt      <= wr_cnt_next;
      busy        <= busy_next;
      done        <= done_next;
      ovf         <= ovf_next;
      err_restart <= err_next;
    end
  end

  ltf_ring_fifo #(
    .DEPTH (DEPTH),
    .W     (DW + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   ({wr_last, wr_sample}),
    .mark_last (mark_last),
    .rd_en     (pop),
    .rd_data   (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .dropped   (dropped)
  );

endmodule

// File: tb/tb_ltf_stream_packer.sv
// Directed self-checking bench for ltf_stream_packer (DEPTH 256 and DEPTH 64 instances).
`timescale 1ns/1ps
module tb_ltf_stream_packer;
  import ltf_pkg::*;

  localparam int DW  = 32;
  localparam int MAX = 700;
`ifdef LTF_WINDOW_EN
  localparam int BL  = 161;
  localparam bit WIN = 1'b1;
`else
  localparam int BL  = 160;
  localparam bit WIN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] ltf_sample = '0;
  logic          b_started = 1'b0, s_started = 1'b0;
  logic          b_ready = 1'b0, s_ready = 1'b0;
  logic [DW-1:0] b_tdata, s_tdata;
  logic          b_tvalid, b_tlast, b_busy, b_done, b_ovf, b_err;
  logic          s_tvalid, s_tlast, s_busy, s_done, s_ovf, s_err;
  logic          sel = 1'b0;

  wire [DW-1:0] o_tdata  = sel ? s_tdata  : b_tdata;
  wire          o_tvalid = sel ? s_tvalid : b_tvalid;
  wire          o_tlast  = sel ? s_tlast  : b_tlast;
  wire          o_busy   = sel ? s_busy   : b_busy;
  wire          o_done   = sel ? s_done   : b_done;
  wire          o_ovf    = sel ? s_ovf    : b_ovf;
  wire          o_err    = sel ? s_err    : b_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] rx_data [$];
  logic        rx_last [$];
  int first_hs, last_hs, done_cycle, done_count, last_count, unstable;
  bit          custom = 1'b0;
  logic [31:0] c0 = '0, c32 = '0;

  always #5 clk = ~clk;

  ltf_stream_packer #(.DEPTH(256), .DW(DW)) u_big (
    .clk(clk), .reset(reset), .ltf_started(b_started), .ltf_sample(ltf_sample),
    .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tready(b_ready), .m_tlast(b_tlast),
    .busy(b_busy), .done(b_done), .ovf(b_ovf), .err_restart(b_err)
  );

  ltf_stream_packer #(.DEPTH(64), .DW(DW)) u_small (
    .clk(clk), .reset(reset), .ltf_started(s_started), .ltf_sample(ltf_sample),
    .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_ready), .m_tlast(s_tlast),
    .busy(s_busy), .done(s_done), .ovf(s_ovf), .err_restart(s_err)
  );

  function automatic logic [31:0] ramp(input int n);
    logic [15:0] nn;
    logic [15:0] neg;
    nn  = 16'(n);
    neg = 16'(0) - nn;
    return {nn, neg};
  endfunction

  function automatic logic [31:0] gen(input int n);
    if (custom && n == 0)  return c0;
    if (custom && n == 32) return c32;
    return ramp(n);
  endfunction

  function automatic logic [31:0] tb_halve(input logic [31:0] x);
    logic signed [15:0] a;
    logic signed [15:0] b;
    a = x[31:16];
    b = x[15:0];
    return {16'(a >>> 1), 16'(b >>> 1)};
  endfunction

  function automatic logic [31:0] expv(input int k);
    if (WIN && k == 0)   return tb_halve(gen(0));
    if (WIN && k == 160) return tb_halve(gen(32));
    return gen(k);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One burst: strobe at cycle 0, optional stall, re-strobe or mid-burst reset.
  task automatic applyStimulus(input bit use_small, input int stall, input int restart_at,
                               input int reset_at);
    bit          prev_stall;
    logic [31:0] prev_data;
    bit          strobe;
    bit          rdy;
    rx_data.delete();
    rx_last.delete();
    first_hs = -1; last_hs = -1; done_cycle = -1;
    done_count = 0; last_count = 0; unstable = 0;
    prev_stall = 1'b0; prev_data = '0;
    sel = use_small;
    for (int c = 0; c < MAX; c++) begin
      @(negedge clk);
      strobe     = (c == 0) || (c == restart_at);
      b_started  = use_small ? 1'b0 : strobe;
      s_started  = use_small ? strobe : 1'b0;
      ltf_sample = (c < LTF_LEN) ? gen(c) : 32'hDEAD_BEEF;
      rdy        = (c >= stall);
      b_ready    = rdy;
      s_ready    = rdy;
      if (c == reset_at) begin
        #1;
        checkOutput("pre_rst_busy", 32'(o_busy), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_tvalid", 32'(o_tvalid), 32'd0);
        checkOutput("rst_busy", 32'(o_busy), 32'd0);
        checkOutput("rst_done", 32'(o_done), 32'd0);
        #1 reset = 1'b0;
        b_started = 1'b0;
        s_started = 1'b0;
        return;
      end
      #1;
      if (prev_stall && (!o_tvalid || o_tdata !== prev_data)) unstable++;
      prev_stall = o_tvalid && !rdy;
      prev_data  = o_tdata;
      if (o_tvalid && rdy) begin
        rx_data.push_back(o_tdata);
        rx_last.push_back(o_tlast);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        if (o_tlast) last_count++;
      end
      if (o_done) begin
        done_count++;
        if (done_cycle < 0) done_cycle = c;
      end
      if (done_cycle >= 0 && c >= done_cycle + 2) break;
    end
    checkOutput("done_seen", 32'(done_cycle >= 0), 32'd1);
  endtask

  task automatic checkBurst(input string tag, input int n);
    checkOutput({tag, "_count"}, 32'(rx_data.size()), 32'(n));
    for (int k = 0; k < n && k < rx_data.size(); k++) begin
      checkOutput($sformatf("%s_data[%0d]", tag, k), rx_data[k], expv(k));
      checkOutput($sformatf("%s_last[%0d]", tag, k), 32'(rx_last[k]), 32'(k == n - 1));
    end
    checkOutput({tag, "_last_count"}, 32'(last_count), 32'd1);
    checkOutput({tag, "_done_count"}, 32'(done_count), 32'd1);
    checkOutput({tag, "_done_timing"}, 32'(done_cycle), 32'(last_hs + 1));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", 32'(b_tvalid), 32'd0);
    checkOutput("reset_tdata", b_tdata, 32'd0);
    checkOutput("reset_tlast", 32'(b_tlast), 32'd0);
    checkOutput("reset_busy", 32'(b_busy), 32'd0);
    checkOutput("reset_done", 32'(b_done), 32'd0);
    checkOutput("reset_ovf", 32'(b_ovf), 32'd0);
    checkOutput("reset_err", 32'(b_err), 32'd0);
    reset = 1'b0;

    // Free-flowing burst: back-to-back handshakes starting the cycle after the strobe.
    applyStimulus(1'b0, 0, -1, -1);
    checkBurst("flow", BL);
    checkOutput("flow_first_hs", 32'(first_hs), 32'd1);
    checkOutput("flow_last_hs", 32'(last_hs), 32'(BL));
    checkOutput("flow_ovf", 32'(o_ovf), 32'd0);
    checkOutput("flow_busy_end", 32'(o_busy), 32'd0);

    // Backpressure for 100 cycles: held outputs, nothing lost.
    applyStimulus(1'b0, 100, -1, -1);
    checkBurst("stall", BL);
    checkOutput("stall_first_hs", 32'(first_hs), 32'd100);
    checkOutput("stall_stable", 32'(unstable), 32'd0);
    checkOutput("stall_ovf", 32'(o_ovf), 32'd0);

    // Second strobe mid-burst is flagged and ignored.
    applyStimulus(1'b0, 0, 50, -1);
    checkBurst("restart", BL);
    checkOutput("restart_err", 32'(o_err), 32'd1);

    applyStimulus(1'b0, 0, -1, -1);
    checkBurst("clear", BL);
    checkOutput("clear_err", 32'(o_err), 32'd0);

    // Small buffer overflows; the last tag moves to the 64th surviving entry.
    applyStimulus(1'b1, 200, -1, -1);
    checkBurst("ovf", 64);
    checkOutput("ovf_flag", 32'(o_ovf), 32'd1);

    applyStimulus(1'b0, 0, -1, 80);
    applyStimulus(1'b0, 0, -1, -1);
    checkBurst("post_rst", BL);
    checkOutput("post_rst_ovf", 32'(o_ovf), 32'd0);

`ifdef LTF_WINDOW_EN
    custom = 1'b1;
    c0  = 32'h7FFE_8002;
    c32 = 32'h0400_FC00;
    applyStimulus(1'b0, 0, -1, -1);
    checkOutput("win_count", 32'(rx_data.size()), 32'd161);
    if (rx_data.size() > 160) begin
      checkOutput("win_first", rx_data[0], 32'h3FFF_C001);
      checkOutput("win_ext", rx_data[160], 32'h0200_FE00);
      checkOutput("win_ext_last", 32'(rx_last[160]), 32'd1);
    end
    custom = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
